// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with hold-time limit
//
// Purpose:
//   Shares one resource between four requesters. The grant is registered and
//   one-hot, with a matching binary address and valid flag, so gnt_addr and
//   gnt_valid can drive a 2-to-4 decoder's addr/en inputs directly. An owner
//   that keeps its request while others wait is rotated out after HOLD_MAX
//   grant cycles.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles while others wait (1..255)
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req[3:0]   in   request vector, req[i]=1 -> requester i wants the resource
//   lock       in   (RR_ARBITER_LOCK_EN only) suppresses preemption while set
//   gnt[3:0]   out  registered one-hot grant, zero when idle
//   gnt_addr   out  binary index of current owner, holds last value when idle
//   gnt_valid  out  high when gnt is non-zero
//   preempt    out  one-cycle pulse when an owner was forcibly rotated out
//
// Optional feature macro: RR_ARBITER_LOCK_EN

module rr_arbiter_4 #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef RR_ARBITER_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] gnt_addr,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // hold_cnt value on the owner's last allowed cycle while others wait
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e           state_q,   state_d;
  logic [1:0]       ptr_q,     ptr_d;
  logic [CNT_W-1:0] hold_q,    hold_d;
  logic [3:0]       gnt_q,     gnt_d;
  logic [1:0]       addr_q,    addr_d;
  logic             valid_q,   valid_d;
  logic             preempt_q, preempt_d;

  logic [3:0] owner_mask;
  logic [3:0] req_others;
  logic [2:0] pick_all;
  logic [2:0] pick_others;
  logic       lock_active;

  // Round-robin pick: first set bit scanning start, start+1, ... mod 4.
  // Returns {found, index}. Scanning from the far end down lets the entry
  // closest to start overwrite the result last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

`ifdef RR_ARBITER_LOCK_EN
  assign lock_active = lock;
`else
  assign lock_active = 1'b0;
`endif

  assign owner_mask  = 4'b0001 << addr_q;
  assign req_others  = req & ~owner_mask;
  assign pick_all    = rr_pick(req, ptr_q);
  assign pick_others = rr_pick(req_others, ptr_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          gnt_d   = 4'b0001 << pick_all[1:0];
          addr_d  = pick_all[1:0];
          valid_d = 1'b1;
          ptr_d   = pick_all[1:0] + 2'd1;
          hold_d  = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (!req[addr_q]) begin
          // Release wins over hold expiry, so no preempt here.
          if (pick_others[2]) begin
            gnt_d   = 4'b0001 << pick_others[1:0];
            addr_d  = pick_others[1:0];
            valid_d = 1'b1;
            ptr_d   = pick_others[1:0] + 2'd1;
            hold_d  = '0;
          end else begin
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if ((hold_q == HOLD_LAST) && (|req_others) && !lock_active) begin
          // pick_others is guaranteed to find someone since req_others != 0.
          gnt_d     = 4'b0001 << pick_others[1:0];
          addr_d    = pick_others[1:0];
          valid_d   = 1'b1;
          ptr_d     = pick_others[1:0] + 2'd1;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          // Saturates so an uncontested owner can hold indefinitely and be
          // preempted on the first edge where competition appears.
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      gnt_q     <= 4'b0000;
      addr_q    <= 2'd0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_addr  = addr_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - scoreboard bench for rr_arbiter_4

module tb_rr_arbiter_4;

  localparam int HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       lock = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_addr;
  logic       gnt_valid;
  logic       preempt;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef RR_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_addr  (gnt_addr),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;

  // Reference model: owner index (-1 = nobody), rotation start, cycles held - 1.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_addr  = 0;
  bit m_pre   = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] r, input int start, input int skip);
    for (int off = 0; off < 4; off++) begin
      int idx;
      idx = (start + off) % 4;
      if (idx != skip && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_grant(input int k);
    m_owner = k;
    m_addr  = k;
    m_ptr   = (k + 1) % 4;
    m_hold  = 0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_addr  = 0;
    m_pre   = 1'b0;
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, 2'(m_addr), (m_owner >= 0), m_pre};
  endfunction

  // Advance the model by one clock edge with the given sampled inputs.
  task automatic step_model(input logic [3:0] r, input logic l);
    int  k;
    int  o;
    bit  others;
    m_pre = 1'b0;
    o = m_owner;
    if (o < 0) begin
      k = pick(r, m_ptr, -1);
      if (k >= 0) model_grant(k);
    end else begin
      others = 1'b0;
      for (int i = 0; i < 4; i++) if (i != o && r[i]) others = 1'b1;
      if (!r[o]) begin
        k = pick(r, m_ptr, o);
        if (k >= 0) model_grant(k);
        else m_owner = -1;
      end else if (m_hold == HOLD - 1 && others && !l) begin
        model_grant(pick(r, m_ptr, o));
        m_pre = 1'b1;
      end else if (m_hold < HOLD - 1) begin
        m_hold++;
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic cyc(input logic [3:0] r, input logic l);
    @(negedge clk);
    req  = r;
    lock = l;
    step_model(r, l);
  endtask

  // Monitor: one expected entry per clock edge while enabled.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle{gnt,addr,valid,preempt}", {gnt, gnt_addr, gnt_valid, preempt}, e);
        check("inv_valid_eq_or_gnt", {7'b0, gnt_valid}, {7'b0, |gnt});
        if (gnt_valid) check("inv_gnt_at_addr", {7'b0, gnt[gnt_addr]}, 8'd1);
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       l;
    bool_done: begin end

    // Reset with all requests high
    rst_n = 1'b0;
    req   = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_gnt",     {4'b0, gnt},       8'h00);
    check("rst_addr",    {6'b0, gnt_addr},  8'h00);
    check("rst_valid",   {7'b0, gnt_valid}, 8'h00);
    check("rst_preempt", {7'b0, preempt},   8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step_model(4'hF, 1'b0);
    mon_en = 1'b1;

    // Rotation: owner drops its request after two cycles of ownership
    for (int i = 0; i < 24; i++) begin
      r = 4'hF;
      if (m_owner >= 0 && m_hold == 1) r[m_owner] = 1'b0;
      cyc(r, 1'b0);
    end

    // Single requester, uncontested long hold, then release
    repeat (40) cyc(4'b0100, 1'b0);
    repeat (3)  cyc(4'b0000, 1'b0);

    // Preemption ping-pong between 0 and 3
    repeat (2)  cyc(4'b0001, 1'b0);
    repeat (40) cyc(4'b1001, 1'b0);

    // Release colliding with hold expiry
    repeat (2) cyc(4'b0000, 1'b0);
    cyc(4'b0001, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (m_owner == 0 && m_hold == HOLD - 1) begin
        cyc(4'b0010, 1'b0);
        break;
      end
      cyc(4'b0011, 1'b0);
    end
    repeat (3) cyc(4'b0010, 1'b0);

`ifdef RR_ARBITER_LOCK_EN
    // Lock suppresses preemption of owner 2
    repeat (2)  cyc(4'b0000, 1'b0);
    repeat (2)  cyc(4'b0100, 1'b0);
    repeat (30) cyc(4'b0101, 1'b1);
    repeat (3)  cyc(4'b0101, 1'b0);
`endif

    // Asynchronous reset in the middle of a grant
    repeat (3) cyc(4'b1111, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt",     {4'b0, gnt},       8'h00);
    check("async_rst_valid",   {7'b0, gnt_valid}, 8'h00);
    check("async_rst_preempt", {7'b0, preempt},   8'h00);
    check("async_rst_addr",    {6'b0, gnt_addr},  8'h00);
    mon_en = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1100;
    lock  = 1'b0;
    step_model(4'b1100, 1'b0);
    mon_en = 1'b1;

    // Randomized traffic with sticky requests
    r = 4'b1100;
    l = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      if (m_owner >= 0 && $urandom_range(9) == 0) r[m_owner] = 1'b0;
`ifdef RR_ARBITER_LOCK_EN
      if ($urandom_range(15) == 0) l = ~l;
`endif
      cyc(r, l);
    end
    repeat (3) cyc(4'b0000, 1'b0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
